shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Command sequencer that sits directly upstream of the 8-bit multi-mode shift register and drives its `control`, `x` and `y` inputs. It accepts one command: an op code, a load value and a step count. It then issues that op code for the requested number of clock cycles and reports completion. Between commands it holds the register contents by reloading its fed-back value, because the shift register has no native hold code.

## Interface
Parameters:
- `CNT_W`, default 4: width of the step count; maximum run is 2^CNT_W−1 steps.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  command strobe; sampled only in IDLE
- `op`  input  3  shift-register op code (0 clr, 1 load, 2 lsr, 3 lsl, 4 asr, 5 serial-in right, 6 ror, 7 rol)
- `load_val`  input  8  value for op 1
- `count`  input  CNT_W  number of cycles to apply ops 2–7
- `serial_in`  input  1  bit stream for op 5
- `sr_out`  input  8  fed back from the shift register's `out`
- `control`  output  3  to shift register `control`
- `x`  output  8  to shift register `x`
- `y`  output  1  to shift register `y`
- `busy`  output  1  high from the cycle after `start` acceptance through DONE
- `done`  output  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
- Registered: state, latched op, latched load value, remaining-step counter, `done`. `control`, `x`, `y` and `busy` are combinational decodes of the registered state.
- IDLE:
  - `control`=1, `x`=`sr_out`, `y`=0. This is the hold behaviour.
  - `start`=1 latches `op`, `load_val` and `count`.
  - Ops 0 and 1 go to RUN with the counter set to 1; `count` is ignored.
  - Ops 2–7 with `count`≠0 go to RUN with the counter set to `count`.
  - Ops 2–7 with `count`=0 go straight to DONE; no shift is issued.
- RUN:
  - `control`=latched op.
  - `x`=latched load value for op 1, otherwise `sr_out`.
  - `y`=`serial_in` when op=5, otherwise 0. It is passed through combinationally, so the register samples `serial_in` at the same edge.
  - The counter decrements each cycle. When the counter=1 at the edge, the next state is DONE.
- DONE:
  - Outputs are the same as in IDLE (hold).
  - `done`=1 for exactly this cycle.
  - Next state is IDLE.
- `start` in RUN or DONE is ignored; it is not queued.
- `busy`=1 in RUN and DONE, and 0 in IDLE.

## Timing
- `start` is accepted at edge k. RUN occupies cycles k+1 … k+N, where N is the step count. DONE is at cycle k+N+1. `busy` falls at edge k+N+2.
- Total latency from acceptance to `done` is N+1 cycles; for the zero-count case it is 1 cycle.
- Back-to-back commands: a new `start` may be accepted in the first IDLE cycle after DONE. Minimum command spacing is N+2 cycles.
- Reset:
  - While `rst`=1, outputs are forced to `control`=0, `x`=0, `y`=0, `busy`=0, `done`=0. The downstream register therefore clears on the same edges.
  - At the first edge with `rst` sampled high, the state becomes IDLE, the counter 0, the latches 0 and `done` 0.
  - Reset during RUN abandons the command; no `done` pulse is generated.
- `count` is unsigned. The counter never wraps because the RUN exit occurs at the value 1.

## Configuration
- `SHIFT_SEQ_ABORT_EN`
  - Defined: adds input `abort` (1 bit). `abort`=1 sampled in RUN forces the next state to DONE. The abort edge itself still applies the op, and `done` pulses normally. `abort` is ignored in IDLE and DONE.
  - Not defined: no `abort` port; RUN always completes all N steps.

## Structure
- `shift_seq_pkg`:
  - state type (IDLE/RUN/DONE)
  - op code constants `OP_CLR`…`OP_ROL` (0–7)
  - `OP_LOAD`, used as the hold code
- One sub-module, `shift_step_cnt`: a loadable down-counter of width `CNT_W` with a `last` flag (value==1). It is instantiated once.

## Test plan
Each scenario is checked with the shift register model connected on `control`/`x`/`y`/`sr_out`.
- Reset held for 2 cycles with register=0xA5: register becomes 0x00; `busy`=0, `done`=0, `control`=0 during reset.
- `op`=1, `load_val`=0x3C, then idle for 5 cycles: register=0x3C at the cycle after acceptance and stays 0x3C (hold); `done` pulses 2 cycles after acceptance.
- Load 0x81, then `op`=7, `count`=3: register goes 0x03→0x06→0x0C; `busy` is high for 4 cycles; `done` is high on the 4th cycle after acceptance.
- Load 0x80, then `op`=4, `count`=2: register goes 0xC0→0xE0. Then `op`=5, `count`=4 with `serial_in`=1,0,1,1: register goes 0xF0→0x78→0xBC→0xDE.
- `op`=2, `count`=0: register is unchanged; `done` is 1 cycle after acceptance. A `start` pulsed during RUN of a `count`=5 command is ignored: register is shifted exactly 5 times, with only one `done`.
- `rst` asserted in the 2nd RUN cycle of `op`=6, `count`=6: register=0x00, no `done` pulse. With `SHIFT_SEQ_ABORT_EN` defined, `abort` in the 2nd RUN cycle gives exactly 2 shifts and `done` on the next cycle.

Source files
------------

// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_pkg
//  Description : Shared types and constants for the shift-register command
//                sequencer: FSM state type and shift-register op codes.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Op codes understood by the downstream 8-bit shift register
    localparam logic [2:0] OP_CLR  = 3'd0;  // clear
    localparam logic [2:0] OP_LOAD = 3'd1;  // parallel load from x
    localparam logic [2:0] OP_LSR  = 3'd2;  // logical shift right
    localparam logic [2:0] OP_LSL  = 3'd3;  // logical shift left
    localparam logic [2:0] OP_ASR  = 3'd4;  // arithmetic shift right
    localparam logic [2:0] OP_SIR  = 3'd5;  // serial-in (y) shift right
    localparam logic [2:0] OP_ROR  = 3'd6;  // rotate right
    localparam logic [2:0] OP_ROL  = 3'd7;  // rotate left

    // The register has no native hold, so holding means reloading its own
    // output through x.
    localparam logic [2:0] OP_HOLD = OP_LOAD;

    // Clear and load are single-shot: the step count does not apply to them.
    function automatic logic op_is_single(input logic [2:0] op_code);
        return (op_code == OP_CLR) || (op_code == OP_LOAD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : shift_step_cnt
//  Description : Loadable down-counter of remaining shift steps with a flag
//                that marks the final step (value == 1).
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_load          - load i_load_val (has priority over i_dec)
//                i_load_val      - value to load
//                i_dec           - decrement by one (saturates at zero)
//                o_last          - current value equals one
//  Revision    : 1.0  initial release
// ============================================================================
module shift_step_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_ctrl
//  Description : Command sequencer in front of the 8-bit multi-mode shift
//                register. Accepts {op, load_val, count}, issues the op for
//                the requested number of cycles, pulses done, and holds the
//                register contents (reload of sr_out) between commands.
//  Config      : `SHIFT_SEQ_ABORT_EN adds the abort input, which ends a RUN
//                early (the abort edge still applies the op).
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                start       - command strobe, honoured only in IDLE
//                op          - shift-register op code to issue
//                load_val    - value for the load op
//                count       - steps for ops 2..7 (0 = no shift)
//                serial_in   - bit stream for serial-in shift right
//                sr_out      - fed back from the shift register output
//                abort       - (optional) terminate RUN early
//                control/x/y - drive the shift register
//                busy        - command in progress (RUN or DONE)
//                done        - one-cycle completion pulse
//  Revision    : 1.0  initial release
// ============================================================================
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [7:0]       load_val,
    input  logic [CNT_W-1:0] count,
    input  logic             serial_in,
    input  logic [7:0]       sr_out,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [2:0]       control,
    output logic [7:0]       x,
    output logic             y,
    output logic             busy,
    output logic             done
);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [2:0]       r_op;
    logic [7:0]       r_load;
    logic             r_done;

    logic             w_accept;
    logic             w_single;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic             w_last;
    logic             w_abort;

`ifdef SHIFT_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept       = (r_state == IDLE) && start;
    assign w_single       = op_is_single(op);
    // Single-shot ops always run exactly one cycle regardless of count.
    assign w_cnt_load_val = w_single ? CNT_W'(1) : count;

    shift_step_cnt #(
        .CNT_W      (CNT_W)
    ) u_step_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (w_cnt_load_val),
        .i_dec      (r_state == RUN),
        .o_last     (w_last)
    );

    // ------------------------------------------------------------------
    // State register and command latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_load  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // done is high exactly for the cycle spent in DONE
            r_done  <= (w_next_state == DONE);
            if (w_accept) begin
                r_op   <= op;
                r_load <= load_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and shift-register drive
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        control      = OP_HOLD;
        x            = sr_out;
        y            = 1'b0;
        busy         = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    // A zero-step shift command completes without issuing
                    // anything to the register.
                    if (w_single || (count != '0)) begin
                        w_next_state = RUN;
                    end else begin
                        w_next_state = DONE;
                    end
                end
            end
            RUN: begin
                control = r_op;
                x       = (r_op == OP_LOAD) ? r_load : sr_out;
                // Passed straight through so the register samples the
                // serial bit present at the same edge.
                y       = (r_op == OP_SIR) ? serial_in : 1'b0;
                busy    = 1'b1;
                if (w_last || w_abort) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Reset drives a clear into the register on the same edges.
        if (rst) begin
            control = OP_CLR;
            x       = '0;
            y       = 1'b0;
            busy    = 1'b0;
        end
    end

    assign done = r_done && !rst;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_seq_ctrl
//  Description : Testbench for shift_seq_ctrl with an 8-bit shift register
//                model closed around control/x/y/sr_out. Expected register
//                value, busy and done are queued per cycle when a command is
//                driven and compared as the cycles elapse.
//  Config      : honours `SHIFT_SEQ_ABORT_EN for the abort scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       op = '0;
    logic [7:0]       load_val = '0;
    logic [CNT_W-1:0] count = '0;
    logic             serial_in = 1'b0;
    logic [7:0]       sr_out;
    logic [2:0]       control;
    logic [7:0]       x;
    logic             y;
    logic             busy;
    logic             done;
`ifdef SHIFT_SEQ_ABORT_EN
    logic             abort = 1'b0;
`endif

    logic             preload = 1'b1;
    logic [7:0]       sr;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] sr;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];

    // Per-scenario stimulus knobs used while draining the scoreboard
    int         stray_idx = -1;
    int         rst_idx   = -1;
    int         abort_idx = -1;
    logic [7:0] sin_bits  = '0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .load_val  (load_val),
        .count     (count),
        .serial_in (serial_in),
        .sr_out    (sr_out),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .control   (control),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .done      (done)
    );

    // Downstream 8-bit multi-mode shift register
    function automatic logic [7:0] sr_next(input logic [2:0] c, input logic [7:0] xv,
                                           input logic yv, input logic [7:0] q);
        case (c)
            3'd0:    return 8'h00;
            3'd1:    return xv;
            3'd2:    return {1'b0, q[7:1]};
            3'd3:    return {q[6:0], 1'b0};
            3'd4:    return {q[7], q[7:1]};
            3'd5:    return {yv, q[7:1]};
            3'd6:    return {q[0], q[7:1]};
            default: return {q[6:0], q[7]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (preload) sr <= 8'hA5;
        else         sr <= sr_next(control, x, y, sr);
    end
    assign sr_out = sr;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] s, input logic b, input logic d);
        exp_t e;
        e.sr   = s;
        e.busy = b;
        e.done = d;
        exp_q.push_back(e);
    endtask

    // Present a command; it is accepted at the next rising edge.
    task automatic issue(input logic [2:0] o, input logic [7:0] lv, input logic [CNT_W-1:0] n);
        start    = 1'b1;
        op       = o;
        load_val = lv;
        count    = n;
    endtask

    // Step one cycle per queued expectation and compare after each edge.
    task automatic drain(input string tag);
        exp_t e;
        int   i;
        i = 0;
        while ((exp_q.size() != 0) && (i < 64)) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("%s[%0d].sr", tag, i), sr, e.sr);
            chk($sformatf("%s[%0d].busy", tag, i), 8'(busy), 8'(e.busy));
            chk($sformatf("%s[%0d].done", tag, i), 8'(done), 8'(e.done));
            // inputs for the next edge
            if (i == stray_idx) begin
                start = 1'b1;
                op    = OP_CLR;
            end else begin
                start = 1'b0;
            end
            serial_in = (i < 8) ? sin_bits[i[2:0]] : 1'b0;
            rst       = (i == rst_idx);
`ifdef SHIFT_SEQ_ABORT_EN
            abort     = (i == abort_idx);
`endif
            i++;
        end
        stray_idx = -1;
        rst_idx   = -1;
        abort_idx = -1;
        sin_bits  = '0;
    endtask

    initial begin
        // Reset with register preloaded to 0xA5
        @(posedge clk);
        #1;
        preload = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.control", 8'(control), 8'h00);
        chk("rst.x", x, 8'h00);
        chk("rst.y", 8'(y), 8'h00);
        chk("rst.busy", 8'(busy), 8'h00);
        chk("rst.done", 8'(done), 8'h00);
        @(posedge clk);
        #1;
        chk("rst.sr", sr, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle.control", 8'(control), 8'(OP_HOLD));
        chk("idle.busy", 8'(busy), 8'h00);

        // Load 0x3C then hold for several idle cycles
        issue(OP_LOAD, 8'h3C, 4'd9);
        push(8'h00, 1, 0); push(8'h3C, 1, 1);
        for (int k = 0; k < 5; k++) push(8'h3C, 0, 0);
        drain("load3c");

        // Load 0x81, rotate left 3
        issue(OP_LOAD, 8'h81, 4'd0);
        push(8'h3C, 1, 0); push(8'h81, 1, 1); push(8'h81, 0, 0);
        drain("load81");
        issue(OP_ROL, 8'h00, 4'd3);
        push(8'h81, 1, 0); push(8'h03, 1, 0); push(8'h06, 1, 0);
        push(8'h0C, 1, 1); push(8'h0C, 0, 0);
        drain("rol3");

        // Load 0x80, arithmetic right 2, serial-in right 4 with 1,0,1,1
        issue(OP_LOAD, 8'h80, 4'd0);
        push(8'h0C, 1, 0); push(8'h80, 1, 1); push(8'h80, 0, 0);
        drain("load80");
        issue(OP_ASR, 8'h00, 4'd2);
        push(8'h80, 1, 0); push(8'hC0, 1, 0); push(8'hE0, 1, 1); push(8'hE0, 0, 0);
        drain("asr2");
        issue(OP_SIR, 8'h00, 4'd4);
        serial_in = 1'b0;
        sin_bits  = 8'b0000_1101;
        push(8'hE0, 1, 0); push(8'hF0, 1, 0); push(8'h78, 1, 0);
        push(8'hBC, 1, 0); push(8'hDE, 1, 1); push(8'hDE, 0, 0);
        drain("sir4");

        // Zero-count shift completes in one cycle with no shift
        issue(OP_LSR, 8'h00, 4'd0);
        push(8'hDE, 1, 1); push(8'hDE, 0, 0); push(8'hDE, 0, 0);
        drain("lsr0");

        // Stray start (clear) during RUN must be ignored
        issue(OP_LSR, 8'h00, 4'd5);
        stray_idx = 1;
        push(8'hDE, 1, 0); push(8'h6F, 1, 0); push(8'h37, 1, 0); push(8'h1B, 1, 0);
        push(8'h0D, 1, 0); push(8'h06, 1, 1); push(8'h06, 0, 0); push(8'h06, 0, 0);
        push(8'h06, 0, 0);
        drain("lsr5");

        // Reset in the 2nd RUN cycle abandons the command without done
        issue(OP_ROR, 8'h00, 4'd6);
        rst_idx = 1;
        push(8'h06, 1, 0); push(8'h03, 1, 0); push(8'h00, 0, 0);
        for (int k = 0; k < 6; k++) push(8'h00, 0, 0);
        drain("rorrst");

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort in the 2nd RUN cycle: two shifts then done
        issue(OP_LOAD, 8'h81, 4'd0);
        push(8'h00, 1, 0); push(8'h81, 1, 1); push(8'h81, 0, 0);
        drain("load81b");
        issue(OP_ROL, 8'h00, 4'd6);
        abort_idx = 1;
        push(8'h81, 1, 0); push(8'h03, 1, 0); push(8'h06, 1, 1);
        push(8'h06, 0, 0); push(8'h06, 0, 0);
        drain("abort");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
